// File: rtl/boxhead_pkg.sv
// ----------------------------------------------------------------------------
// boxhead_pkg
// Shared types and constants for the Boxhead sprite overlays.
//   overlay_state_t : HIDDEN / SLIDE / BLINK state of an animated overlay
//   COORD_W         : width of the DrawX/DrawY screen coordinates
//   CMP_W           : width used for box compares (one bit wider, so no wrap)
//   ROM_ADDR_W      : width of a sprite ROM address
//   PIX_W           : width of a palette index
//   GAMEOVER_SPR_*  : default dimensions of the "game over" sprite
// ----------------------------------------------------------------------------
package boxhead_pkg;

    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        SLIDE  = 2'd1,
        BLINK  = 2'd2
    } overlay_state_t;

    localparam int COORD_W    = 10;
    localparam int CMP_W      = 11;
    localparam int ROM_ADDR_W = 15;
    localparam int PIX_W      = 5;

    localparam int GAMEOVER_SPR_W = 211;
    localparam int GAMEOVER_SPR_H = 25;

    // Zero-extend a screen coordinate to the compare width.
    function automatic logic [CMP_W-1:0] widen(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// ----------------------------------------------------------------------------
// sprite_addr_gen
// Combinational box test and sprite ROM address for a sprite whose left edge
// is fixed at POS_X and whose top edge is POS_Y shifted down by y_off rows.
//   draw_x, draw_y : current pixel position
//   y_off          : extra downward offset of the sprite top edge
//   in_box         : current pixel lies inside the sprite rectangle
//   rom_addr       : row-major address inside the sprite, 0 outside the box
// ----------------------------------------------------------------------------
module sprite_addr_gen
    import boxhead_pkg::*;
#(
    parameter int SPR_W = GAMEOVER_SPR_W,
    parameter int SPR_H = GAMEOVER_SPR_H,
    parameter int POS_X = 0,
    parameter int POS_Y = 0
) (
    input  logic [COORD_W-1:0]    draw_x,
    input  logic [COORD_W-1:0]    draw_y,
    input  logic [COORD_W-1:0]    y_off,
    output logic                  in_box,
    output logic [ROM_ADDR_W-1:0] rom_addr
);

    logic [CMP_W-1:0] x_w;
    logic [CMP_W-1:0] y_w;
    logic [CMP_W-1:0] left;
    logic [CMP_W-1:0] right;
    logic [CMP_W-1:0] top;
    logic [CMP_W-1:0] bottom;
    logic [CMP_W-1:0] dx;
    logic [CMP_W-1:0] dy;

    // All edges are computed one bit wider than the screen coordinates, so a
    // sprite pushed far down by y_off can never wrap back onto the screen.
    // right and bottom are exclusive bounds.
    always_comb begin
        x_w    = widen(draw_x);
        y_w    = widen(draw_y);
        left   = CMP_W'(POS_X);
        right  = CMP_W'(POS_X + SPR_W);
        top    = CMP_W'(POS_Y) + widen(y_off);
        bottom = top + CMP_W'(SPR_H);
        in_box = (x_w >= left) && (x_w < right) && (y_w >= top) && (y_w < bottom);
        dx     = x_w - left;
        dy     = y_w - top;
        rom_addr = '0;
        if (in_box) begin
            rom_addr = ROM_ADDR_W'(dy) * ROM_ADDR_W'(SPR_W) + ROM_ADDR_W'(dx);
        end
    end

endmodule

// File: rtl/gameover_overlay.sv
// ----------------------------------------------------------------------------
// gameover_overlay
// "Game over" banner: when game_over rises the sprite slides up into place
// over several frames, then blinks until game_over falls.
//   Clk, Reset_n  : system clock, asynchronous active-low reset
//   frame_start   : one-cycle pulse at the start of each frame
//   game_over     : level, high while the banner should be shown
//   DrawX, DrawY  : current pixel position
//   rom_addr      : combinational address to the external sprite ROM
//   rom_data      : ROM palette index, one cycle after rom_addr
//   pixel_on      : overlay pixel opaque and visible (aligned to pixel_index)
//   pixel_index   : palette index of the overlay pixel
// ----------------------------------------------------------------------------
module gameover_overlay
    import boxhead_pkg::*;
#(
    parameter int              SPR_W        = GAMEOVER_SPR_W,
    parameter int              SPR_H        = GAMEOVER_SPR_H,
    parameter int              POS_X        = 214,
    parameter int              POS_Y        = 227,
    parameter int              SLIDE_DIST   = 64,
    parameter int              SLIDE_STEP   = 4,
    parameter int              BLINK_FRAMES = 30,
    parameter logic [PIX_W-1:0] TRANSP      = 5'h00
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_start,
    input  logic                  game_over,
    input  logic [COORD_W-1:0]    DrawX,
    input  logic [COORD_W-1:0]    DrawY,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]      rom_data,
    output logic                  pixel_on,
    output logic [PIX_W-1:0]      pixel_index
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    overlay_state_t     state;
    overlay_state_t     state_nx;
    logic [COORD_W-1:0] y_off;
    logic [COORD_W-1:0] y_off_nx;
    logic [CNT_W-1:0]   blink_cnt;
    logic [CNT_W-1:0]   blink_cnt_nx;
    logic               vis;
    logic               vis_nx;
    logic               in_box;
    logic               flag_nx;
    logic               flag_d;

    // Box test and ROM address for the sprite at its current slide position.
    sprite_addr_gen #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .POS_X (POS_X),
        .POS_Y (POS_Y)
    ) u_addr_gen (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .y_off    (y_off),
        .in_box   (in_box),
        .rom_addr (rom_addr)
    );

    // Animation state register. Everything here only moves at frame_start
    // (or when game_over drops), so a frame is always drawn from one
    // consistent position and visibility.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= HIDDEN;
            y_off     <= '0;
            blink_cnt <= '0;
            vis       <= 1'b0;
        end else begin
            state     <= state_nx;
            y_off     <= y_off_nx;
            blink_cnt <= blink_cnt_nx;
            vis       <= vis_nx;
        end
    end

    // Next-state logic. Dropping game_over wins over a coincident
    // frame_start and hides the banner at once. The slide saturates at zero
    // and hands over to blinking on the same frame the offset reaches zero.
    always_comb begin
        state_nx     = state;
        y_off_nx     = y_off;
        blink_cnt_nx = blink_cnt;
        vis_nx       = vis;
        if (!game_over) begin
            state_nx     = HIDDEN;
            y_off_nx     = '0;
            blink_cnt_nx = '0;
            vis_nx       = 1'b0;
        end else if (frame_start) begin
            case (state)
                HIDDEN: begin
                    state_nx     = SLIDE;
                    y_off_nx     = COORD_W'(SLIDE_DIST);
                    blink_cnt_nx = '0;
                    vis_nx       = 1'b1;
                end
                SLIDE: begin
                    if (y_off > COORD_W'(SLIDE_STEP)) begin
                        y_off_nx = y_off - COORD_W'(SLIDE_STEP);
                    end else begin
                        y_off_nx     = '0;
                        state_nx     = BLINK;
                        blink_cnt_nx = '0;
                    end
                end
                BLINK: begin
                    if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_nx = '0;
                        vis_nx       = ~vis;
                    end else begin
                        blink_cnt_nx = blink_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx     = HIDDEN;
                    y_off_nx     = '0;
                    blink_cnt_nx = '0;
                    vis_nx       = 1'b0;
                end
            endcase
        end
    end

    // Output logic. The ROM answers one cycle after the address, so the
    // visibility decision is delayed by one register to line up with
    // rom_data; transparent palette entries never light a pixel.
    always_comb begin
        flag_nx     = in_box & vis & (state != HIDDEN);
        pixel_index = rom_data;
        pixel_on    = flag_d & (rom_data != TRANSP);
    end

    // Visibility pipeline stage matching the ROM read latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flag_d <= 1'b0;
        end else begin
            flag_d <= flag_nx;
        end
    end

endmodule

// File: tb/tb_gameover_overlay.sv
// ----------------------------------------------------------------------------
// tb_gameover_overlay
// Self-checking bench for gameover_overlay with a one-cycle sprite ROM model
// and a scoreboard queue of expected {pixel_on, pixel_index} values.
// ----------------------------------------------------------------------------
module tb_gameover_overlay;

    localparam int SPR_W        = 211;
    localparam int SPR_H        = 25;
    localparam int POS_X        = 214;
    localparam int POS_Y        = 227;
    localparam int SLIDE_DIST   = 64;
    localparam int SLIDE_STEP   = 4;
    localparam int BLINK_FRAMES = 30;
    localparam logic [4:0] TRANSP = 5'h00;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [14:0] rom_addr;
    logic [4:0]  rom_data = '0;
    logic        pixel_on;
    logic [4:0]  pixel_index;

    int errors = 0;
    int checks = 0;

    // Reference model of the animation state (0 hidden, 1 slide, 2 blink).
    int m_state = 0;
    int m_yoff  = 0;
    int m_cnt   = 0;
    bit m_vis   = 1'b0;
    bit transp_all = 1'b0;

    logic [5:0] exp_q[$];

    gameover_overlay #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .POS_X(POS_X), .POS_Y(POS_Y),
        .SLIDE_DIST(SLIDE_DIST), .SLIDE_STEP(SLIDE_STEP),
        .BLINK_FRAMES(BLINK_FRAMES), .TRANSP(TRANSP)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .game_over(game_over), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_on(pixel_on), .pixel_index(pixel_index)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM contents: 3 at address 0, never transparent elsewhere
    // unless transp_all is set.
    function automatic logic [4:0] rom_val(input int a);
        if (transp_all) return TRANSP;
        if (a == 0) return 5'h03;
        return 5'((a % 31) + 1);
    endfunction

    always @(posedge Clk) rom_data <= rom_val(int'(rom_addr));

    function automatic bit m_in_box(input int x, input int y);
        int top;
        top = POS_Y + m_yoff;
        return (x >= POS_X) && (x < POS_X + SPR_W) && (y >= top) && (y < top + SPR_H);
    endfunction

    function automatic int m_addr(input int x, input int y);
        if (!m_in_box(x, y)) return 0;
        return (y - POS_Y - m_yoff) * SPR_W + (x - POS_X);
    endfunction

    function automatic logic [5:0] m_pixel(input int x, input int y);
        logic [4:0] v;
        v = rom_val(m_addr(x, y));
        return {m_in_box(x, y) && m_vis && (m_state != 0) && (v != TRANSP), v};
    endfunction

    task automatic model_hide();
        m_state = 0; m_yoff = 0; m_cnt = 0; m_vis = 1'b0;
    endtask

    // One frame_start pulse, with the model advanced to match.
    task automatic frame_pulse();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        if (!game_over) begin
            model_hide();
        end else if (m_state == 0) begin
            m_state = 1; m_yoff = SLIDE_DIST; m_vis = 1'b1; m_cnt = 0;
        end else if (m_state == 1) begin
            m_yoff = (m_yoff > SLIDE_STEP) ? m_yoff - SLIDE_STEP : 0;
            if (m_yoff == 0) begin
                m_state = 2; m_cnt = 0;
            end
        end else begin
            if (m_cnt == BLINK_FRAMES - 1) begin
                m_cnt = 0; m_vis = !m_vis;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] e;
        int xs[3] = '{300, 0, 214};
        int ys[3] = '{240, 0, 227};
        Reset_n = 1'b0;
        game_over = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pixel_on: got %0d expected 0", pixel_on);
        end
        checks++;
        if (rom_addr !== 15'd0) begin
            errors++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", rom_addr);
        end
        Reset_n = 1'b1;
        model_hide();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 2;
                if (pixel_on !== e[5]) begin
                    errors++; $display("[TB] FAIL hidden_pixel_on: got %0d expected %0d", pixel_on, e[5]);
                end
                if (pixel_index !== e[4:0]) begin
                    errors++; $display("[TB] FAIL hidden_pixel_index: got %0d expected %0d", pixel_index, e[4:0]);
                end
            end
            DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
            #1;
            checks++;
            if (rom_addr !== 15'(m_addr(xs[i], ys[i]))) begin
                errors++; $display("[TB] FAIL hidden_rom_addr: got %0d expected %0d", rom_addr, m_addr(xs[i], ys[i]));
            end
            exp_q.push_back(m_pixel(xs[i], ys[i]));
        end
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (pixel_on !== e[5]) begin
            errors++; $display("[TB] FAIL hidden_pixel_on_last: got %0d expected %0d", pixel_on, e[5]);
        end
    endtask

    task automatic test_slide();
        logic [5:0] e;
        int xs[2];
        int ys[2];
        @(negedge Clk);
        game_over = 1'b1;
        for (int f = 0; f <= SLIDE_DIST / SLIDE_STEP; f++) begin
            frame_pulse();
            xs = '{215 + f, 220};
            ys = '{POS_Y + m_yoff, POS_Y + m_yoff - 1};
            for (int i = 0; i < 2; i++) begin
                @(negedge Clk);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks += 2;
                    if (pixel_on !== e[5]) begin
                        errors++; $display("[TB] FAIL slide_pixel_on f%0d: got %0d expected %0d", f, pixel_on, e[5]);
                    end
                    if (pixel_index !== e[4:0]) begin
                        errors++; $display("[TB] FAIL slide_pixel_index f%0d: got %0d expected %0d", f, pixel_index, e[4:0]);
                    end
                end
                DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
                #1;
                checks++;
                if (rom_addr !== 15'(m_addr(xs[i], ys[i]))) begin
                    errors++; $display("[TB] FAIL slide_rom_addr f%0d: got %0d expected %0d", f, rom_addr, m_addr(xs[i], ys[i]));
                end
                exp_q.push_back(m_pixel(xs[i], ys[i]));
            end
            @(negedge Clk);
            e = exp_q.pop_front();
            checks++;
            if (pixel_on !== e[5]) begin
                errors++; $display("[TB] FAIL slide_pixel_on_last f%0d: got %0d expected %0d", f, pixel_on, e[5]);
            end
        end
    endtask

    task automatic test_addr_bounds();
        logic [5:0] e;
        int xs[7] = '{214, 424, 213, 425, 424, 214, 214};
        int ys[7] = '{227, 251, 227, 227, 227, 226, 252};
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 2;
                if (pixel_on !== e[5]) begin
                    errors++; $display("[TB] FAIL bound_pixel_on %0d: got %0d expected %0d", i, pixel_on, e[5]);
                end
                if (pixel_index !== e[4:0]) begin
                    errors++; $display("[TB] FAIL bound_pixel_index %0d: got %0d expected %0d", i, pixel_index, e[4:0]);
                end
            end
            DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
            #1;
            checks++;
            if (rom_addr !== 15'(m_addr(xs[i], ys[i]))) begin
                errors++; $display("[TB] FAIL bound_rom_addr %0d: got %0d expected %0d", i, rom_addr, m_addr(xs[i], ys[i]));
            end
            exp_q.push_back(m_pixel(xs[i], ys[i]));
        end
        @(negedge Clk);
        e = exp_q.pop_front();
        checks += 2;
        if (pixel_on !== e[5]) begin
            errors++; $display("[TB] FAIL bound_pixel_on_last: got %0d expected %0d", pixel_on, e[5]);
        end
        if (pixel_index !== e[4:0]) begin
            errors++; $display("[TB] FAIL bound_pixel_index_last: got %0d expected %0d", pixel_index, e[4:0]);
        end
    endtask

    task automatic test_transparent();
        @(negedge Clk);
        transp_all = 1'b1;
        DrawX = 10'd214; DrawY = 10'd227;
        @(negedge Clk);
        checks += 2;
        if (pixel_on !== 1'b0) begin
            errors++; $display("[TB] FAIL transp_pixel_on: got %0d expected 0", pixel_on);
        end
        if (pixel_index !== TRANSP) begin
            errors++; $display("[TB] FAIL transp_pixel_index: got %0d expected %0d", pixel_index, TRANSP);
        end
        transp_all = 1'b0;
        @(negedge Clk);
        checks += 2;
        if (pixel_on !== 1'b1) begin
            errors++; $display("[TB] FAIL opaque_pixel_on: got %0d expected 1", pixel_on);
        end
        if (pixel_index !== 5'h03) begin
            errors++; $display("[TB] FAIL opaque_pixel_index: got %0d expected 3", pixel_index);
        end
    endtask

    task automatic test_blink();
        logic [5:0] e;
        int offs = 0;
        for (int f = 1; f <= 2 * BLINK_FRAMES; f++) begin
            frame_pulse();
            @(negedge Clk);
            DrawX = 10'd300; DrawY = 10'd240;
            exp_q.push_back(m_pixel(300, 240));
            @(negedge Clk);
            e = exp_q.pop_front();
            checks++;
            if (pixel_on !== e[5]) begin
                errors++; $display("[TB] FAIL blink_pixel_on f%0d: got %0d expected %0d", f, pixel_on, e[5]);
            end
            if (!m_vis) offs++;
        end
        checks++;
        if (offs != BLINK_FRAMES) begin
            errors++; $display("[TB] FAIL blink_off_frames: got %0d expected %0d", offs, BLINK_FRAMES);
        end
    endtask

    task automatic test_abort();
        @(negedge Clk);
        game_over = 1'b0;
        @(negedge Clk);
        model_hide();
        game_over = 1'b1;
        repeat (3) frame_pulse();
        @(negedge Clk);
        DrawX = 10'd215; DrawY = 10'(POS_Y + m_yoff);
        #1;
        checks++;
        if (rom_addr !== 15'd1) begin
            errors++; $display("[TB] FAIL abort_pre_rom_addr: got %0d expected 1", rom_addr);
        end
        @(negedge Clk);
        checks++;
        if (pixel_on !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_pre_pixel_on: got %0d expected 1", pixel_on);
        end
        frame_start = 1'b1;
        game_over = 1'b0;
        @(negedge Clk);
        frame_start = 1'b0;
        model_hide();
        #1;
        checks++;
        if (rom_addr !== 15'(m_addr(215, int'(DrawY)))) begin
            errors++; $display("[TB] FAIL abort_rom_addr: got %0d expected %0d", rom_addr, m_addr(215, int'(DrawY)));
        end
        @(negedge Clk);
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_pixel_on: got %0d expected 0", pixel_on);
        end
        frame_pulse();
        @(negedge Clk);
        DrawX = 10'd215; DrawY = 10'd227;
        @(negedge Clk);
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_hidden_pixel_on: got %0d expected 0", pixel_on);
        end
        game_over = 1'b1;
        frame_pulse();
        @(negedge Clk);
        DrawX = 10'd215; DrawY = 10'(POS_Y + SLIDE_DIST);
        #1;
        checks++;
        if (rom_addr !== 15'(m_addr(215, POS_Y + SLIDE_DIST))) begin
            errors++; $display("[TB] FAIL reenter_rom_addr: got %0d expected %0d", rom_addr, m_addr(215, POS_Y + SLIDE_DIST));
        end
        @(negedge Clk);
        checks++;
        if (pixel_on !== 1'b1) begin
            errors++; $display("[TB] FAIL reenter_pixel_on: got %0d expected 1", pixel_on);
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [5:0] e;
        while (m_state != 2) frame_pulse();
        @(negedge Clk);
        DrawX = 10'd300; DrawY = 10'd240;
        e = m_pixel(300, 240);
        @(negedge Clk);
        checks++;
        if (pixel_on !== e[5]) begin
            errors++; $display("[TB] FAIL midblink_pixel_on: got %0d expected %0d", pixel_on, e[5]);
        end
        #2;
        Reset_n = 1'b0;
        model_hide();
        #1;
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset_pixel_on: got %0d expected 0", pixel_on);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (pixel_on !== 1'b0) begin
                errors++; $display("[TB] FAIL post_reset_pixel_on %0d: got %0d expected 0", i, pixel_on);
            end
        end
        frame_pulse();
        @(negedge Clk);
        DrawX = 10'd215; DrawY = 10'(POS_Y + m_yoff);
        exp_q.push_back(m_pixel(215, POS_Y + m_yoff));
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (pixel_on !== e[5]) begin
            errors++; $display("[TB] FAIL post_reset_slide_pixel_on: got %0d expected %0d", pixel_on, e[5]);
        end
    endtask

    initial begin
        $display("[TB] gameover_overlay bench start");
        test_reset();
        test_slide();
        test_addr_bounds();
        test_transparent();
        test_blink();
        test_abort();
        test_reset_mid_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
